// File: rtl/spi_master_param.sv
// rtl/spi_master_param.sv - Parameterised SPI master with register port and TX/RX FIFOs
module spi_master_param #(
  parameter int DATABITS   = 8,
  parameter int NUMSLAVES  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [2:0]           mem_addr,
  input  logic [15:0]          data_from_cpu,
  input  logic                 read_n,
  input  logic                 write_n,
  input  logic                 spi_select,
  output logic [15:0]          data_to_cpu,
  output logic                 irq,
  input  logic                 MISO,
  output logic                 MOSI,
  output logic                 SCLK,
  output logic [NUMSLAVES-1:0] SS_n
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [5:0]    LAST_EDGE = 6'(2 * DATABITS - 1);
  // status bits that may raise irq: ROE, TOE, TRDY, RRDY, E
  localparam logic [15:0]   IRQ_MASK  = 16'h01D8;

  localparam logic [2:0] A_RXDATA = 3'd0;
  localparam logic [2:0] A_TXDATA = 3'd1;
  localparam logic [2:0] A_STATUS = 3'd2;
  localparam logic [2:0] A_CTRL   = 3'd3;
  localparam logic [2:0] A_CLKDIV = 3'd4;
  localparam logic [2:0] A_SLVEN  = 3'd5;
  localparam logic [2:0] A_MODE   = 3'd6;

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_SHIFT, ST_HOLD} state_t;

  state_t state;

  // CPU-visible registers
  logic [15:0]          ctrl_r;
  logic [15:0]          clkdiv_r;
  logic [NUMSLAVES-1:0] slave_en_r;
  logic [2:0]           mode_r;
  logic                 roe;
  logic                 toe;

  // FIFOs
  logic [DATABITS-1:0]  tx_mem [FIFO_DEPTH];
  logic [DATABITS-1:0]  rx_mem [FIFO_DEPTH];
  logic [AW-1:0]        tx_wptr, tx_rptr, rx_wptr, rx_rptr;
  logic [CW-1:0]        tx_cnt, rx_cnt;

  // engine datapath, configuration latched per frame
  logic [15:0]          cnt;
  logic [15:0]          clkdiv_l;
  logic                 cpha_l;
  logic                 lsbf_l;
  logic [5:0]           edge_cnt;
  logic [DATABITS-1:0]  tx_sr;
  logic [DATABITS-1:0]  rx_sr;

  logic wr_en, rd_en;
  logic tx_empty, tx_full, rx_empty, rx_full;
  logic tx_push_req, tx_push, toe_set;
  logic rx_pop_req, rx_pop, rx_push_req, rx_push, roe_set;
  logic st_clr, busy, tick, load;
  logic [DATABITS-1:0] tx_head, tx_next, rx_in;
  logic head_bit, cur_bit, next_bit;
  logic [15:0] rx_cnt16;
  logic [3:0]  rx_lvl;
  logic [15:0] status;

  assign wr_en       = spi_select & ~write_n;
  assign rd_en       = spi_select & ~read_n;
  assign tx_empty    = (tx_cnt == '0);
  assign tx_full     = (tx_cnt == DEPTH_C);
  assign rx_empty    = (rx_cnt == '0);
  assign rx_full     = (rx_cnt == DEPTH_C);
  assign busy        = (state != ST_IDLE);
  assign tick        = (cnt == clkdiv_l);
  // a new frame starts from IDLE, or straight out of HOLD so back-to-back frames have no gap
  assign load        = ((state == ST_IDLE) || (state == ST_HOLD && tick)) && !tx_empty;

  assign tx_push_req = wr_en && (mem_addr == A_TXDATA);
  assign tx_push     = tx_push_req && (!tx_full || load);
  assign toe_set     = tx_push_req && tx_full && !load;
  assign rx_pop_req  = rd_en && (mem_addr == A_RXDATA);
  assign rx_pop      = rx_pop_req && !rx_empty;
  assign rx_push_req = (state == ST_HOLD) && tick;
  assign rx_push     = rx_push_req && (!rx_full || rx_pop);
  assign roe_set     = rx_push_req && rx_full && !rx_pop;
  assign st_clr      = wr_en && (mem_addr == A_STATUS);

  // bit selection and shifting for MSB-first or LSB-first frames
  always_comb begin
    tx_head  = tx_mem[tx_rptr];
    head_bit = mode_r[2] ? tx_head[0] : tx_head[DATABITS-1];
    tx_next  = lsbf_l ? (tx_sr >> 1) : (tx_sr << 1);
    cur_bit  = lsbf_l ? tx_sr[0] : tx_sr[DATABITS-1];
    next_bit = lsbf_l ? tx_next[0] : tx_next[DATABITS-1];
    rx_in    = lsbf_l ? {MISO, rx_sr[DATABITS-1:1]} : {rx_sr[DATABITS-2:0], MISO};
  end

  // status word with RX level saturated to four bits
  always_comb begin
    rx_cnt16 = 16'(rx_cnt);
    rx_lvl   = (rx_cnt16 > 16'd15) ? 4'hF : rx_cnt16[3:0];
    status   = {rx_lvl, 2'b00, busy, roe | toe, !rx_empty, !tx_full,
                tx_empty && !busy, toe, roe, 3'b000};
  end

  // TX FIFO pointers and occupancy
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_wptr <= '0;
      tx_rptr <= '0;
      tx_cnt  <= '0;
    end else begin
      if (tx_push) tx_wptr <= tx_wptr + AW'(1);
      if (load)    tx_rptr <= tx_rptr + AW'(1);
      case ({tx_push, load})
        2'b10:   tx_cnt <= tx_cnt + CW'(1);
        2'b01:   tx_cnt <= tx_cnt - CW'(1);
        default: tx_cnt <= tx_cnt;
      endcase
    end
  end

  // TX FIFO storage
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wptr] <= data_from_cpu[DATABITS-1:0];
  end

  // RX FIFO pointers and occupancy
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_wptr <= '0;
      rx_rptr <= '0;
      rx_cnt  <= '0;
    end else begin
      if (rx_push) rx_wptr <= rx_wptr + AW'(1);
      if (rx_pop)  rx_rptr <= rx_rptr + AW'(1);
      case ({rx_push, rx_pop})
        2'b10:   rx_cnt <= rx_cnt + CW'(1);
        2'b01:   rx_cnt <= rx_cnt - CW'(1);
        default: rx_cnt <= rx_cnt;
      endcase
    end
  end

  // RX FIFO storage
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wptr] <= rx_sr;
  end

  // CPU-writable configuration and sticky overrun flags
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_r     <= '0;
      clkdiv_r   <= 16'h0004;
      slave_en_r <= NUMSLAVES'(1);
      mode_r     <= '0;
      roe        <= 1'b0;
      toe        <= 1'b0;
    end else begin
      if (wr_en) begin
        case (mem_addr)
          A_CTRL:   ctrl_r     <= data_from_cpu;
          A_CLKDIV: clkdiv_r   <= data_from_cpu;
          A_SLVEN:  slave_en_r <= data_from_cpu[NUMSLAVES-1:0];
          A_MODE:   mode_r     <= data_from_cpu[2:0];
          default:  ;
        endcase
      end
      if (roe_set)     roe <= 1'b1;
      else if (st_clr) roe <= 1'b0;
      if (toe_set)     toe <= 1'b1;
      else if (st_clr) toe <= 1'b0;
    end
  end

  // registered read data; an empty RX FIFO reads as zero
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_to_cpu <= '0;
    end else if (rd_en) begin
      case (mem_addr)
        A_RXDATA: data_to_cpu <= rx_empty ? 16'h0000 : 16'(rx_mem[rx_rptr]);
        A_STATUS: data_to_cpu <= status;
        A_CTRL:   data_to_cpu <= ctrl_r;
        A_CLKDIV: data_to_cpu <= clkdiv_r;
        A_SLVEN:  data_to_cpu <= 16'(slave_en_r);
        A_MODE:   data_to_cpu <= {13'd0, mode_r};
        default:  data_to_cpu <= 16'h0000;
      endcase
    end
  end

  // interrupt follows enabled status bits one cycle later
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) irq <= 1'b0;
    else          irq <= |(status & ctrl_r & IRQ_MASK);
  end

  // frame engine: IDLE -> SETUP -> SHIFT -> HOLD with registered serial outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      clkdiv_l <= '0;
      cpha_l   <= 1'b0;
      lsbf_l   <= 1'b0;
      edge_cnt <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      SCLK     <= 1'b0;
      MOSI     <= 1'b0;
      SS_n     <= '1;
    end else if (load) begin
      state    <= ST_SETUP;
      cnt      <= '0;
      clkdiv_l <= clkdiv_r;
      cpha_l   <= mode_r[1];
      lsbf_l   <= mode_r[2];
      edge_cnt <= '0;
      tx_sr    <= tx_head;
      rx_sr    <= '0;
      SCLK     <= mode_r[0];
      MOSI     <= head_bit;
      SS_n     <= ~slave_en_r;
    end else begin
      case (state)
        ST_IDLE: begin
          SCLK <= mode_r[0];
          MOSI <= 1'b0;
          SS_n <= ctrl_r[10] ? ~slave_en_r : '1;
        end
        ST_SETUP: begin
          if (tick) begin
            state <= ST_SHIFT;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        ST_SHIFT: begin
          if (tick) begin
            cnt      <= '0;
            SCLK     <= ~SCLK;
            edge_cnt <= edge_cnt + 6'd1;
            // edge_cnt[0]==0 marks an odd (1st, 3rd, ...) edge
            if (edge_cnt[0] == cpha_l) begin
              rx_sr <= rx_in;
            end else begin
              MOSI  <= cpha_l ? cur_bit : next_bit;
              tx_sr <= tx_next;
            end
            if (edge_cnt == LAST_EDGE) state <= ST_HOLD;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        ST_HOLD: begin
          if (tick) begin
            state <= ST_IDLE;
            cnt   <= '0;
            MOSI  <= 1'b0;
            SS_n  <= ctrl_r[10] ? ~slave_en_r : '1;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_param.sv
// tb/tb_spi_master_param.sv - Self-checking bench for spi_master_param
module tb_spi_master_param;

  localparam logic [2:0] A_RX   = 3'd0;
  localparam logic [2:0] A_TX   = 3'd1;
  localparam logic [2:0] A_STAT = 3'd2;
  localparam logic [2:0] A_CTRL = 3'd3;
  localparam logic [2:0] A_DIV  = 3'd4;
  localparam logic [2:0] A_SLV  = 3'd5;
  localparam logic [2:0] A_MODE = 3'd6;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  mem_addr = 3'd0;
  logic [15:0] data_from_cpu = 16'h0000;
  logic        read_n = 1'b1;
  logic        write_n = 1'b1;
  logic        spi_select = 1'b0;
  logic [15:0] data_to_cpu;
  logic        irq;
  logic        MISO;
  logic        MOSI;
  logic        SCLK;
  logic [3:0]  SS_n;

  assign MISO = MOSI;

  spi_master_param #(.DATABITS(8), .NUMSLAVES(4), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset_n(reset_n), .mem_addr(mem_addr), .data_from_cpu(data_from_cpu),
    .read_n(read_n), .write_n(write_n), .spi_select(spi_select),
    .data_to_cpu(data_to_cpu), .irq(irq), .MISO(MISO), .MOSI(MOSI),
    .SCLK(SCLK), .SS_n(SS_n)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [2:0]  mode;
    logic [15:0] div;
    logic [7:0]  tx;
    logic        exp_idle;
    logic        exp_first;
    logic [7:0]  exp_lead;
    int          exp_period;
  } vec_t;

  vec_t vecs[6];

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cpu_write(input logic [2:0] a, input logic [15:0] d);
    mem_addr = a;
    data_from_cpu = d;
    spi_select = 1'b1;
    write_n = 1'b0;
    @(posedge clk);
    #1;
    spi_select = 1'b0;
    write_n = 1'b1;
  endtask

  task automatic cpu_read(input logic [2:0] a, output logic [15:0] d);
    mem_addr = a;
    spi_select = 1'b1;
    read_n = 1'b0;
    @(posedge clk);
    #1;
    spi_select = 1'b0;
    read_n = 1'b1;
    d = data_to_cpu;
  endtask

  task automatic check_rx(input string name);
    logic [15:0] d;
    logic [7:0]  e;
    cpu_read(A_RX, d);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: got 0x%0h but scoreboard is empty", name, d);
    end else begin
      e = exp_q.pop_front();
      check16(name, d, {8'h00, e});
    end
  endtask

  task automatic wait_tmt(input int budget, output bit ok);
    logic [15:0] s;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      cpu_read(A_STAT, s);
      if (s[5]) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // follows one frame on SS_n[0]: first MOSI bit, SCLK toggles, bits on leading edges
  task automatic watch_frame(input logic cpol, input int exp_period,
                             output bit started, output bit ended, output logic first_bit,
                             output int toggles, output logic [7:0] lead_bits,
                             output int bad_periods);
    int cyc;
    int last;
    logic prev;
    started = 1'b0; ended = 1'b0; first_bit = 1'b0;
    toggles = 0; lead_bits = '0; bad_periods = 0; cyc = 0; last = -1;
    while (SS_n[0] !== 1'b0 && cyc < 50) begin
      @(posedge clk); #1; cyc++;
    end
    if (SS_n[0] === 1'b0) begin
      started = 1'b1;
      first_bit = MOSI;
      prev = SCLK;
      cyc = 0;
      while (SS_n[0] === 1'b0 && cyc < 2000) begin
        @(posedge clk); #1; cyc++;
        if (SCLK !== prev) begin
          toggles++;
          if (prev === cpol) begin
            lead_bits = {lead_bits[6:0], MOSI};
            if (last >= 0 && (cyc - last) != exp_period) bad_periods++;
            last = cyc;
          end
          prev = SCLK;
        end
      end
      ended = (SS_n[0] === 1'b1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rd;
    bit started, ended, ok;
    logic fb;
    int tg, bp, cyc, bad;
    logic [7:0] lb;
    logic prev;

    vecs[0] = '{3'b000, 16'd4, 8'hA5, 1'b0, 1'b1, 8'hA5, 10};
    vecs[1] = '{3'b111, 16'd4, 8'h01, 1'b1, 1'b1, 8'h80, 10};
    vecs[2] = '{3'b010, 16'd2, 8'h3C, 1'b0, 1'b0, 8'h3C, 6};
    vecs[3] = '{3'b101, 16'd0, 8'hC1, 1'b1, 1'b1, 8'h83, 2};
    vecs[4] = '{3'b000, 16'd1, 8'hFF, 1'b0, 1'b1, 8'hFF, 4};
    vecs[5] = '{3'b100, 16'd3, 8'h12, 1'b0, 1'b0, 8'h48, 8};

    // reset state
    tick(3);
    check1("rst sclk", SCLK, 1'b0);
    check1("rst mosi", MOSI, 1'b0);
    check16("rst ss_n", {12'h000, SS_n}, 16'h000F);
    check1("rst irq", irq, 1'b0);
    check16("rst data_to_cpu", data_to_cpu, 16'h0000);
    reset_n = 1'b1;
    tick(2);
    cpu_read(A_STAT, rd); check16("rst status", rd, 16'h0060);
    cpu_read(A_DIV, rd);  check16("rst clkdiv", rd, 16'h0004);
    cpu_read(A_SLV, rd);  check16("rst slave_en", rd, 16'h0001);
    cpu_read(A_CTRL, rd); check16("rst control", rd, 16'h0000);
    cpu_read(A_RX, rd);   check16("rx empty read", rd, 16'h0000);

    // table-driven single frames in loopback
    for (int i = 0; i < 6; i++) begin
      cpu_write(A_MODE, {13'd0, vecs[i].mode});
      cpu_write(A_DIV, vecs[i].div);
      tick(2);
      check1($sformatf("v%0d sclk idle", i), SCLK, vecs[i].exp_idle);
      cpu_write(A_TX, {8'h00, vecs[i].tx});
      exp_q.push_back(vecs[i].tx);
      watch_frame(vecs[i].exp_idle, vecs[i].exp_period, started, ended, fb, tg, lb, bp);
      check1($sformatf("v%0d ss_n fell", i), started, 1'b1);
      check1($sformatf("v%0d ss_n rose", i), ended, 1'b1);
      check1($sformatf("v%0d first mosi", i), fb, vecs[i].exp_first);
      check_int($sformatf("v%0d sclk toggles", i), tg, 16);
      check16($sformatf("v%0d mosi bits", i), {8'h00, lb}, {8'h00, vecs[i].exp_lead});
      check_int($sformatf("v%0d bad periods", i), bp, 0);
      cpu_read(A_STAT, rd);
      check1($sformatf("v%0d rrdy set", i), rd[7], 1'b1);
      check_rx($sformatf("v%0d rxdata", i));
      cpu_read(A_STAT, rd);
      check1($sformatf("v%0d rrdy clear", i), rd[7], 1'b0);
    end

    // RX overrun: five frames, no reads
    cpu_write(A_MODE, 16'h0000);
    cpu_write(A_DIV, 16'd1);
    cpu_write(A_CTRL, 16'h0008);
    for (int i = 1; i <= 5; i++) begin
      cpu_write(A_TX, 16'(i * 16'h11));
      exp_q.push_back(8'(i * 8'h11));
    end
    void'(exp_q.pop_back());
    wait_tmt(1000, ok);
    check1("roe frames done", ok, 1'b1);
    cpu_read(A_STAT, rd); check16("roe status", rd, 16'h41E8);
    check1("roe irq", irq, 1'b1);
    for (int i = 0; i < 4; i++) check_rx($sformatf("roe rx%0d", i));
    cpu_read(A_RX, rd); check16("roe 5th read", rd, 16'h0000);
    cpu_write(A_STAT, 16'h0000);
    cpu_read(A_STAT, rd); check16("roe cleared status", rd, 16'h0060);
    check1("roe irq cleared", irq, 1'b0);
    cpu_write(A_CTRL, 16'h0000);

    // forced select held across and between frames
    cpu_write(A_SLV, 16'h0004);
    cpu_write(A_CTRL, 16'h0400);
    tick(2);
    check16("sso idle ss_n", {12'h000, SS_n}, 16'h000B);
    bad = 0;
    for (int f = 0; f < 2; f++) begin
      cpu_write(A_TX, 16'(8'h69 + f));
      exp_q.push_back(8'(8'h69 + f));
      for (int c = 0; c < 60; c++) begin
        @(posedge clk); #1;
        if (SS_n !== 4'b1011) bad++;
      end
    end
    check_int("sso ss_n deviations", bad, 0);
    check_rx("sso rx0");
    check_rx("sso rx1");
    cpu_write(A_CTRL, 16'h0000);
    cpu_write(A_SLV, 16'h0001);
    tick(2);
    check16("sso off ss_n", {12'h000, SS_n}, 16'h000F);

    // reset in the middle of frame 2 of 3
    cpu_write(A_DIV, 16'd4);
    cpu_write(A_TX, 16'h005A);
    cpu_write(A_TX, 16'h00E3);
    cpu_write(A_TX, 16'h000F);
    tg = 0; cyc = 0; prev = SCLK;
    while (tg < 21 && cyc < 3000) begin
      @(posedge clk); #1; cyc++;
      if (SCLK !== prev) begin
        tg++;
        prev = SCLK;
      end
    end
    check_int("midrst reached frame2", tg, 21);
    #2;
    reset_n = 1'b0;
    #1;
    check1("midrst sclk", SCLK, 1'b0);
    check1("midrst mosi", MOSI, 1'b0);
    check16("midrst ss_n", {12'h000, SS_n}, 16'h000F);
    tick(1);
    reset_n = 1'b1;
    tick(3);
    check16("midrst ss_n after", {12'h000, SS_n}, 16'h000F);
    cpu_read(A_STAT, rd); check16("midrst status", rd, 16'h0060);

    // TX overrun with a very slow clock divider
    cpu_write(A_DIV, 16'hFFFF);
    for (int i = 0; i < 6; i++) cpu_write(A_TX, 16'(8'hB0 + i));
    cpu_read(A_STAT, rd); check16("toe status", rd, 16'h0310);
    check1("toe irq masked", irq, 1'b0);
    cpu_write(A_CTRL, 16'h0010);
    tick(1);
    check1("toe irq", irq, 1'b1);
    cpu_write(A_STAT, 16'h0000);
    cpu_read(A_STAT, rd); check16("toe cleared status", rd, 16'h0200);
    check1("toe irq cleared", irq, 1'b0);
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    tick(1);

    check_int("scoreboard drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
